// File: rtl/gmii_tx_arbiter.sv
// Two-source GMII transmit arbiter: round-robin at frame boundaries, preamble/SFD
// insertion, inter-frame gap, max-length enforcement and underrun error signalling.
module gmii_tx_arbiter #(
   parameter int PREAMBLE_BYTES = 7,
   parameter int IFG_BYTES      = 12,
   parameter int MAX_BYTES      = 1518
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s0_data,
   input  logic       s0_valid,
   input  logic       s0_last,
   output logic       s0_ready,
   input  logic [7:0] s1_data,
   input  logic       s1_valid,
   input  logic       s1_last,
   output logic       s1_ready,
   output logic [7:0] tx_data,
   output logic       tx_en,
   output logic       tx_er,
   output logic [1:0] grant,
   output logic       tx_abort
);

   localparam int CW = $clog2(MAX_BYTES + 2);
   localparam int TW = $clog2(PREAMBLE_BYTES + IFG_BYTES + 1);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DRAIN, IFG} state_t;

   state_t        state, state_nx;
   logic [1:0]    grant_nx;
   logic          last_grant, last_grant_nx;
   logic          pick;
   logic [CW-1:0] byte_cnt, byte_cnt_nx;
   logic [TW-1:0] tmr, tmr_nx;
   logic [7:0]    data_nx;
   logic          en_nx, er_nx, abort_nx;

   logic [7:0]    sel_data;
   logic          sel_valid, sel_last, accepting;

   assign sel_data  = grant[1] ? s1_data  : s0_data;
   assign sel_valid = grant[1] ? s1_valid : s0_valid;
   assign sel_last  = grant[1] ? s1_last  : s0_last;
   assign accepting = (state == DATA) || (state == DRAIN);
   assign s0_ready  = accepting & grant[0];
   assign s1_ready  = accepting & grant[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         grant      <= 2'b00;
         last_grant <= 1'b1;
         byte_cnt   <= '0;
         tmr        <= '0;
         tx_data    <= 8'h00;
         tx_en      <= 1'b0;
         tx_er      <= 1'b0;
         tx_abort   <= 1'b0;
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         last_grant <= last_grant_nx;
         byte_cnt   <= byte_cnt_nx;
         tmr        <= tmr_nx;
         tx_data    <= data_nx;
         tx_en      <= en_nx;
         tx_er      <= er_nx;
         tx_abort   <= abort_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      grant_nx      = grant;
      last_grant_nx = last_grant;
      byte_cnt_nx   = byte_cnt;
      tmr_nx        = tmr;
      pick          = 1'b0;
      data_nx       = 8'h00;
      en_nx         = 1'b0;
      er_nx         = 1'b0;
      abort_nx      = 1'b0;
      case (state)
         IDLE: begin
            grant_nx = 2'b00;
            if (s0_valid || s1_valid) begin
               // pick=1 selects source 1; a tie goes to whoever did not win last
               pick          = (s0_valid && s1_valid) ? ~last_grant : s1_valid;
               grant_nx      = pick ? 2'b10 : 2'b01;
               last_grant_nx = pick;
               tmr_nx        = TW'(PREAMBLE_BYTES - 1);
               state_nx      = PRE;
            end
         end
         PRE: begin
            data_nx = 8'h55;
            en_nx   = 1'b1;
            if (tmr == '0) state_nx = SFD;
            else           tmr_nx   = tmr - 1'b1;
         end
         SFD: begin
            data_nx     = 8'hD5;
            en_nx       = 1'b1;
            byte_cnt_nx = '0;
            state_nx    = DATA;
         end
         DATA: begin
            if (!sel_valid) begin
               en_nx    = 1'b1;
               er_nx    = 1'b1;
               abort_nx = 1'b1;
               state_nx = DRAIN;
            end else if (byte_cnt == CW'(MAX_BYTES)) begin
               // byte MAX_BYTES+1 is swallowed and replaced by the error cycle
               en_nx    = 1'b1;
               er_nx    = 1'b1;
               abort_nx = 1'b1;
               if (sel_last) begin
                  grant_nx = 2'b00;
                  tmr_nx   = TW'(IFG_BYTES - 2);
                  state_nx = IFG;
               end else begin
                  state_nx = DRAIN;
               end
            end else begin
               data_nx     = sel_data;
               en_nx       = 1'b1;
               byte_cnt_nx = byte_cnt + 1'b1;
               if (sel_last) begin
                  grant_nx = 2'b00;
                  tmr_nx   = TW'(IFG_BYTES - 2);
                  state_nx = IFG;
               end
            end
         end
         DRAIN: begin
            if (sel_valid && sel_last) begin
               grant_nx = 2'b00;
               tmr_nx   = TW'(IFG_BYTES - 2);
               state_nx = IFG;
            end
         end
         IFG: begin
            // IFG_BYTES-1 cycles here plus the IDLE arbitration cycle give IFG_BYTES low on tx
            if (tmr == '0) state_nx = IDLE;
            else           tmr_nx   = tmr - 1'b1;
         end
         default: begin
            grant_nx = 2'b00;
            state_nx = IDLE;
         end
      endcase
   end

endmodule
